wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_arbiter_if.sv | 42 ++++
 rtl/wb_arb_fifo.sv | 67 ++++++
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: widths, FIFO depth,
// the arbitration state enum and the source-register match helper.
package wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        NORMAL      = 1'b0,
        FORCE_DRAIN = 1'b1
    } arb_state_e;

    // x0 is never a real dependency, so a zero source never matches.
    function automatic logic rs_hit(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd,
        input logic              vld
    );
        return vld && (rs != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline result, MDU result, hazard query and RF write port.
// The arbiter connects through the slave modport, its environment through master.
interface wb_arbiter_if #(
    parameter int XLEN = wb_arbiter_pkg::XLEN
);
    import wb_arbiter_pkg::*;

    logic              pipe_valid;
    logic [REG_AW-1:0] pipe_rd;
    logic [XLEN-1:0]   pipe_data;
    logic              pipe_stall;

    logic              mdu_valid;
    logic [REG_AW-1:0] mdu_rd;
    logic [XLEN-1:0]   mdu_data;
    logic              mdu_ready;

    logic [REG_AW-1:0] q_rs1;
    logic [REG_AW-1:0] q_rs2;
    logic              q_hit;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  mdu_valid, mdu_rd, mdu_data,
        input  q_rs1, q_rs2,
        output pipe_stall, mdu_ready, q_hit,
        output rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output mdu_valid, mdu_rd, mdu_data,
        output q_rs1, q_rs2,
        input  pipe_stall, mdu_ready, q_hit,
        input  rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_arb_fifo.sv
// Two-entry FIFO of pending MDU results ({rd, data}); both slots are exposed
// with their valid flags so the arbiter can answer decode hazard queries.
module wb_arb_fifo #(
    parameter int XLEN = wb_arbiter_pkg::XLEN,
    parameter int AW   = wb_arbiter_pkg::REG_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [AW-1:0]       push_rd,
    input  logic [XLEN-1:0]     push_data,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [AW-1:0]       head_rd,
    output logic [XLEN-1:0]     head_data,
    output logic [1:0]          slot_valid,
    output logic [1:0][AW-1:0]  slot_rd
);
    import wb_arbiter_pkg::*;

    logic [AW-1:0]   rd_mem   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem [FIFO_DEPTH];
    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      count_reg;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= !wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= !rd_ptr_reg;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: slot_valid masks whatever is left behind.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wr_ptr_reg]   <= push_rd;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_rd   = rd_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        assign slot_valid[gi] = full || (!empty && (rd_ptr_reg == 1'(gi)));
        assign slot_rd[gi]    = rd_mem[gi];
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and a buffered MDU.
// Define WB_ARB_STARVE_GUARD_EN to add the starvation counter and FORCE_DRAIN state.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = wb_arbiter_pkg::XLEN
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);
    import wb_arbiter_pkg::*;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [REG_AW-1:0]      head_rd;
    logic [XLEN-1:0]        head_data;
    logic [1:0]             slot_valid;
    logic [1:0][REG_AW-1:0] slot_rd;
    logic [1:0]             slot_hit;

    logic                   mdu_ready_reg;
    logic                   full_next;
    logic                   pipe_win;
    logic                   drain;
    logic                   pipe_stall;
    logic                   rf_we;
    logic [REG_AW-1:0]      rf_waddr;
    logic [XLEN-1:0]        rf_wdata;

    wb_arb_fifo #(
        .XLEN (XLEN),
        .AW   (REG_AW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_rd    (bus.mdu_rd),
        .push_data  (bus.mdu_data),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .slot_valid (slot_valid),
        .slot_rd    (slot_rd)
    );

    // rst_n gates the bypass path so reset silences rf_we without waiting for a clock.
    assign pipe_win  = rst_n && bus.pipe_valid && (bus.pipe_rd != '0);
    assign fifo_push = bus.mdu_valid && mdu_ready_reg;

    // Ready is registered from the post-edge occupancy, never from mdu_valid directly.
    always_comb begin
        full_next = 1'b0;
        if (fifo_full)        full_next = !fifo_pop;
        else if (!fifo_empty) full_next = fifo_push && !fifo_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdu_ready_reg <= 1'b0;
        else        mdu_ready_reg <= !full_next;
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_e    state_reg;
    arb_state_e    state_next;
    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= NORMAL;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Drain is entered on the edge where the counter reaches the limit.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        state_next      = state_reg;
        if (fifo_pop || fifo_empty)
            starve_cnt_next = '0;
        else if (pipe_win && (starve_cnt_reg != CW'(STARVE_LIMIT)))
            starve_cnt_next = starve_cnt_reg + 1'b1;
        case (state_reg)
            NORMAL:      if (starve_cnt_next == CW'(STARVE_LIMIT)) state_next = FORCE_DRAIN;
            FORCE_DRAIN: state_next = NORMAL;
            default:     state_next = NORMAL;
        endcase
    end

    assign drain = (state_reg == FORCE_DRAIN);
`else
    assign drain = 1'b0;
`endif

    always_comb begin
        fifo_pop   = 1'b0;
        pipe_stall = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        if (drain) begin
            pipe_stall = 1'b1;
            fifo_pop   = !fifo_empty;
            rf_we      = !fifo_empty && (head_rd != '0);
            rf_waddr   = head_rd;
            rf_wdata   = head_data;
        end else if (pipe_win) begin
            rf_we      = 1'b1;
            rf_waddr   = bus.pipe_rd;
            rf_wdata   = bus.pipe_data;
        end else if (!fifo_empty) begin
            // An rd=0 entry still leaves the FIFO, just without a write.
            fifo_pop   = 1'b1;
            rf_we      = (head_rd != '0);
            rf_waddr   = head_rd;
            rf_wdata   = head_data;
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hit
        assign slot_hit[gi] = rs_hit(bus.q_rs1, slot_rd[gi], slot_valid[gi])
                           || rs_hit(bus.q_rs2, slot_rd[gi], slot_valid[gi]);
    end

    assign bus.q_hit      = |slot_hit;
    assign bus.mdu_ready  = mdu_ready_reg;
    assign bus.pipe_stall = pipe_stall;
    assign bus.rf_we      = rf_we;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;

endmodule
